// File: rtl/keccak_padder_if.sv
// Message-word input and padded-block output bundle for keccak_padder.
// The master side feeds words and acknowledges blocks; the slave side is the padder.
interface keccak_padder_if #(
  parameter int unsigned WORDS = 18
);
  logic [31:0]         in;
  logic                in_ready;
  logic                is_last;
  logic [1:0]          byte_num;
  logic                buffer_full;
  logic [32*WORDS-1:0] out;
  logic                out_ready;
  logic                f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );
endinterface

// File: rtl/keccak_padder.sv
// Keccak multi-rate padder: packs 32-bit words into 576-bit blocks and applies pad10*1.
// Define KECCAK_PADDER_SHA3_DOMAIN_EN to use the SHA3 domain byte 0x06 instead of 0x01.
module keccak_padder #(
  parameter int unsigned WORDS = 18
) (
  input logic           clk,
  input logic           reset,
  keccak_padder_if.slave bus
);
  localparam int unsigned W = 32 * WORDS;
  localparam logic [4:0] LastIdx = 5'(WORDS - 1);
`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
  localparam logic [7:0] PadByte = 8'h06;
`else
  localparam logic [7:0] PadByte = 8'h01;
`endif

  typedef enum logic [1:0] {StAccum, StPad, StFull, StDone} state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [W-1:0]   out_q, out_d;
  logic           last_q, last_d;
  logic [31:0]    pad_word;

  // Final word: keep the valid bytes, then the domain byte, then zeros.
  always_comb begin
    pad_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < bus.byte_num) begin
        pad_word[31-8*i -: 8] = bus.in[31-8*i -: 8];
      end else if (2'(i) == bus.byte_num) begin
        pad_word[31-8*i -: 8] = PadByte;
      end
    end
    if (cnt_q == LastIdx) begin
      pad_word[7:0] = pad_word[7:0] | 8'h80;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    last_d  = last_q;
    unique case (state_q)
      StAccum: begin
        if (bus.in_ready) begin
          out_d = {out_q[W-33:0], (bus.is_last ? pad_word : bus.in)};
          cnt_d = cnt_q + 5'd1;
          if (bus.is_last) begin
            last_d  = 1'b1;
            state_d = (cnt_q == LastIdx) ? StFull : StPad;
          end else if (cnt_q == LastIdx) begin
            state_d = StFull;
          end
        end
      end
      StPad: begin
        out_d = {out_q[W-33:0], ((cnt_q == LastIdx) ? 32'h0000_0080 : 32'h0)};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIdx) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (bus.f_ack) begin
          cnt_d   = '0;
          state_d = last_q ? StDone : StAccum;
        end
      end
      StDone: begin
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StAccum;
      cnt_q   <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  assign bus.buffer_full = (state_q != StAccum);
  assign bus.out_ready   = (state_q == StFull);
  assign bus.out         = out_q;
endmodule

// File: tb/tb_keccak_padder.sv
// Randomized bench for keccak_padder against a byte-level pad10*1 reference model.
module tb_keccak_padder;
  localparam int unsigned WORDS = 18;
  localparam int unsigned BlkBytes = 4 * WORDS;
`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
  localparam byte unsigned PadByte = 8'h06;
`else
  localparam byte unsigned PadByte = 8'h01;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keccak_padder_if #(.WORDS(WORDS)) bus ();
  keccak_padder #(.WORDS(WORDS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned msg[$];

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.in_ready = 1'($urandom);
    bus.f_ack = 1'b1;
    step();
    reset = 1'b0;
    bus.in_ready = 1'b0;
    bus.f_ack = 1'b0;
    check("rst_out", bus.out, '0);
    check("rst_out_ready", bus.out_ready, 0);
    check("rst_buffer_full", bus.buffer_full, 0);
  endtask

  // Drives raw words with no checking, used to leave the padder mid-block.
  task automatic feed_raw(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) begin
      bus.in = $urandom;
      bus.in_ready = 1'b1;
      bus.is_last = last_at_end && (i == n - 1);
      bus.byte_num = 2'($urandom);
      step();
    end
    bus.in_ready = 1'b0;
    bus.is_last = 1'b0;
  endtask

  // Sends msg as words, then checks every produced block against the padded byte stream.
  task automatic run_msg(input int hold);
    byte unsigned pad[$];
    int nwords, bn, k, lat, blk;
    bit last;
    logic [31:0] w;
    logic [575:0] exp_blk, snap;

    pad = msg;
    pad.push_back(PadByte);
    while (pad.size() % BlkBytes != 0) pad.push_back(8'h00);
    pad[pad.size() - 1] = pad[pad.size() - 1] | 8'h80;

    nwords = msg.size() / 4 + 1;
    bn = msg.size() % 4;
    for (int i = 0; i < nwords; i++) begin
      k = i % WORDS;
      last = (i == nwords - 1);
      for (int b = 0; b < 4; b++) begin
        if (4 * i + b < msg.size()) w[31-8*b -: 8] = msg[4*i+b];
        else w[31-8*b -: 8] = 8'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        bus.in_ready = 1'b0;
        bus.f_ack = 1'b1;
        step();
        bus.f_ack = 1'b0;
      end
      check("buffer_full_accum", bus.buffer_full, 0);
      bus.in = w;
      bus.in_ready = 1'b1;
      bus.is_last = last;
      bus.byte_num = last ? 2'(bn) : 2'($urandom);
      step();
      bus.is_last = 1'b0;
      bus.in_ready = 1'b0;
      if (last || k == WORDS - 1) begin
        lat = 0;
        while (!bus.out_ready && lat < 40) begin
          bus.in_ready = 1'($urandom);
          bus.in = $urandom;
          bus.f_ack = 1'($urandom);
          step();
          lat++;
        end
        bus.in_ready = 1'b0;
        bus.f_ack = 1'b0;
        check("latency", lat, last ? (WORDS - 1 - k) : 0);
        blk = i / WORDS;
        for (int b = 0; b < BlkBytes; b++) exp_blk[575-8*b -: 8] = pad[BlkBytes*blk+b];
        check("out_ready_full", bus.out_ready, 1);
        check("block", bus.out, exp_blk);
        snap = exp_blk;
        for (int h = 0; h < hold; h++) begin
          bus.in_ready = 1'($urandom);
          bus.in = $urandom;
          step();
          check("hold_out", bus.out, snap);
          check("hold_out_ready", bus.out_ready, 1);
          check("hold_buffer_full", bus.buffer_full, 1);
        end
        bus.f_ack = 1'b1;
        bus.in_ready = 1'b1;
        step();
        bus.f_ack = 1'b0;
        bus.in_ready = 1'b0;
        check("ack_out_ready", bus.out_ready, 0);
        check("ack_buffer_full", bus.buffer_full, last ? 1 : 0);
        if (last) begin
          bus.in_ready = 1'b1;
          bus.f_ack = 1'b1;
          step();
          step();
          bus.in_ready = 1'b0;
          bus.f_ack = 1'b0;
          check("done_buffer_full", bus.buffer_full, 1);
          check("done_out_ready", bus.out_ready, 0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in = '0;
    bus.in_ready = 1'b0;
    bus.is_last = 1'b0;
    bus.byte_num = '0;
    bus.f_ack = 1'b0;
    step();
    apply_reset();

    // Empty message.
    msg.delete();
    run_msg(2);

    // 17 words of 0xAA then 11 22 33 as the final partial word.
    apply_reset();
    msg.delete();
    for (int i = 0; i < 68; i++) msg.push_back(8'hAA);
    msg.push_back(8'h11);
    msg.push_back(8'h22);
    msg.push_back(8'h33);
    run_msg(1);

    // Exactly one block of data: full block held 5 cycles, then a pad-only block.
    apply_reset();
    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'($urandom));
    run_msg(5);

    // Two-block message ending at index 2 with one byte 0xDE.
    apply_reset();
    msg.delete();
    for (int i = 0; i < 80; i++) msg.push_back(8'($urandom));
    msg.push_back(8'hDE);
    run_msg(1);

    // Reset mid-ACCUM at index 9, then mid-PAD, then a clean message.
    apply_reset();
    feed_raw(9, 1'b0);
    apply_reset();
    feed_raw(3, 1'b1);
    step();
    step();
    apply_reset();
    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    run_msg(0);

    for (int t = 0; t < 8; t++) begin
      apply_reset();
      msg.delete();
      for (int i = 0; i < $urandom_range(0, 200); i++) msg.push_back(8'($urandom));
      run_msg($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
